// File: rtl/cjg_irq_ctrl_pkg.sv
// ============================================================================
// Module : cjg_irq_ctrl_pkg
// Brief  : Shared constants, types and helpers for the cjg_risc interrupt
//          controller (config register map, FSM states, priority pick).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cjg_irq_ctrl_pkg;

  // Number of interrupt lines; fixed at four in this revision.
  localparam int NUM_IRQ = 4;

  // Config port register map (cfg_addr values).
  localparam logic [1:0] IRQ_CTRL = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_MODE = 2'd2;
  localparam logic [1:0] IRQ_PEND = 2'd3;

  // Request sequencer states.
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // Fixed priority: the lowest-numbered eligible line wins. Scanning from
  // the top down lets the lowest set bit overwrite any higher one.
  function automatic logic [1:0] irq_winner(input logic [NUM_IRQ-1:0] elig);
    logic [1:0] w;
    w = 2'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) w = 2'(i);
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cjg_irq_ctrl_if.sv
// ============================================================================
// Module : cjg_irq_ctrl_if
// Brief  : Core <-> interrupt controller bundle: 4-register config port and
//          the req/ack/done interrupt handshake.
//   cfg_wren/cfg_addr/cfg_wdata : config write (core drives)
//   cfg_rdata                   : config read data (controller drives)
//   int_req/int_vector/int_id   : pending request and its handler address
//   int_ack/int_done            : core accepted / core returned (pulses)
//   int_active                  : an ISR is in service
//   modports: master = core side, slave = controller side
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cjg_irq_ctrl_if;

  logic        cfg_wren;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        int_req;
  logic [15:0] int_vector;
  logic [1:0]  int_id;
  logic        int_ack;
  logic        int_done;
  logic        int_active;

  modport master (
    output cfg_wren, cfg_addr, cfg_wdata, int_ack, int_done,
    input  cfg_rdata, int_req, int_vector, int_id, int_active
  );

  modport slave (
    input  cfg_wren, cfg_addr, cfg_wdata, int_ack, int_done,
    output cfg_rdata, int_req, int_vector, int_id, int_active
  );

endinterface

`default_nettype wire

// File: rtl/cjg_irq_ctrl_sync.sv
// ============================================================================
// Module : cjg_irq_ctrl_sync
// Brief  : Single-line SYNC_STAGES-deep synchroniser with rising-edge detect.
//   clk, rst_n : clock, async active-low reset
//   async_in   : raw asynchronous input
//   level      : synchronised level
//   rise       : one-cycle pulse on a synchronised 0->1 transition
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cjg_irq_ctrl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/cjg_irq_ctrl.sv
// ============================================================================
// Module : cjg_irq_ctrl
// Brief  : Four-line interrupt controller for the cjg_risc core. Synchronises
//          the lines, latches edge/level requests, masks them, picks a
//          fixed-priority winner and sequences it to the core one at a time.
//   clk, rst_n         : clock, async active-low reset (sync release)
//   ext_interrupt_bus  : raw asynchronous lines, active-high
//   bus (slave)        : config port + req/ack/done handshake
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cjg_irq_ctrl
  import cjg_irq_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0004,
  parameter logic [15:0] VEC_STRIDE  = 16'h0004
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] ext_interrupt_bus,
  cjg_irq_ctrl_if.slave      bus
);

  logic [NUM_IRQ-1:0] sync_level;
  logic [NUM_IRQ-1:0] sync_rise;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] eligible;
  logic               ctrl_en_q;
  irq_state_e         state_q;
  irq_state_e         state_d;
  logic               capture;
  logic               ack_take;
  logic [1:0]         winner;
  logic [1:0]         id_q;
  logic [15:0]        vec_d;
  logic [15:0]        vec_q;
  logic               unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata[31:NUM_IRQ];

  // --------------------------------------------------------------------------
  // Per-line synchronisers
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      cjg_irq_ctrl_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_interrupt_bus[g]),
        .level    (sync_level[g]),
        .rise     (sync_rise[g])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pending capture. Edge bits are sticky until W1C or acknowledge; a new
  // edge arriving in the clearing cycle wins. Level bits track the line and
  // ignore clears. Masking is deliberately not applied here.
  // --------------------------------------------------------------------------
  assign ack_take = (state_q == IRQ_REQ) && bus.int_ack;

  always_comb begin
    clr    = '0;
    pend_d = pend_q;
    if (bus.cfg_wren && (bus.cfg_addr == IRQ_PEND)) clr = bus.cfg_wdata[NUM_IRQ-1:0];
    if (ack_take) clr[id_q] = 1'b1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_d[i] = mode_q[i] ? (sync_rise[i] | (pend_q[i] & ~clr[i])) : sync_level[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // --------------------------------------------------------------------------
  // Config registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en_q <= 1'b0;
      mask_q    <= '0;
      mode_q    <= '0;
    end else if (bus.cfg_wren) begin
      case (bus.cfg_addr)
        IRQ_CTRL: ctrl_en_q <= bus.cfg_wdata[0];
        IRQ_MASK: mask_q    <= bus.cfg_wdata[NUM_IRQ-1:0];
        IRQ_MODE: mode_q    <= bus.cfg_wdata[NUM_IRQ-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      IRQ_CTRL: bus.cfg_rdata[0]           = ctrl_en_q;
      IRQ_MASK: bus.cfg_rdata[NUM_IRQ-1:0] = mask_q;
      IRQ_MODE: bus.cfg_rdata[NUM_IRQ-1:0] = mode_q;
      default:  bus.cfg_rdata[NUM_IRQ-1:0] = pend_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Priority select and vector computation (16-bit, wraps)
  // --------------------------------------------------------------------------
  assign eligible = pend_q & mask_q & {NUM_IRQ{ctrl_en_q}};
  assign winner   = irq_winner(eligible);
  assign vec_d    = VEC_BASE + VEC_STRIDE * {14'd0, winner};

  // --------------------------------------------------------------------------
  // Request sequencer. id/vector are captured on IDLE->REQ and then frozen,
  // so later MASK/CTRL/pending changes cannot alter an issued request.
  // In REQ only ack is honoured, in SERVICE only done.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (|eligible) begin
          state_d = IRQ_REQ;
          capture = 1'b1;
        end
      end
      IRQ_REQ: begin
        if (bus.int_ack) state_d = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (bus.int_done) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      id_q    <= 2'd0;
      vec_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        id_q  <= winner;
        vec_q <= vec_d;
      end
    end
  end

  assign bus.int_req    = (state_q == IRQ_REQ);
  assign bus.int_active = (state_q == IRQ_SERVICE);
  assign bus.int_id     = id_q;
  assign bus.int_vector = vec_q;

endmodule

`default_nettype wire

// File: tb/tb_cjg_irq_ctrl.sv
// ============================================================================
// Module : tb_cjg_irq_ctrl
// Brief  : Self-checking bench for cjg_irq_ctrl: directed scenarios plus a
//          randomized run against a cycle-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cjg_irq_ctrl;
  import cjg_irq_ctrl_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ext   = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  cjg_irq_ctrl_if bus();

  cjg_irq_ctrl #(
    .SYNC_STAGES (2),
    .VEC_BASE    (16'h0004),
    .VEC_STRIDE  (16'h0004)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_interrupt_bus (ext),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model. Line history: h1/h2/h3 hold the line value sampled
  // 1/2/3 edges ago. With two sync stages a pending bit reflects the line as
  // it was two edges earlier; an edge event is a 0->1 between h3 and h2.
  // Sequencer phase: 0 idle, 1 requesting, 2 in service.
  // --------------------------------------------------------------------------
  bit   [3:0] m_mask, m_mode, m_pend, h1, h2, h3;
  bit         m_en;
  int         m_phase, m_id;
  logic [15:0] m_vec;

  task automatic model_step();
    bit [3:0] ev, clr, elig;
    int       nphase;
    if (!rst_n) begin
      m_en = 0; m_mask = 0; m_mode = 0; m_pend = 0;
      h1 = 0; h2 = 0; h3 = 0;
      m_phase = 0; m_id = 0; m_vec = 16'd0;
      return;
    end
    ev   = h2 & ~h3;
    clr  = 4'd0;
    if (bus.cfg_wren && bus.cfg_addr == 2'd3) clr = bus.cfg_wdata[3:0];
    elig   = m_en ? (m_pend & m_mask) : 4'd0;
    nphase = m_phase;
    if (m_phase == 0 && elig != 0) begin
      nphase = 1;
      for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
      m_vec = 16'((32'h4 + 32'h4 * m_id) % 65536);
    end else if (m_phase == 1 && bus.int_ack) begin
      nphase = 2;
      clr[m_id] = 1'b1;
    end else if (m_phase == 2 && bus.int_done) begin
      nphase = 0;
    end
    for (int i = 0; i < 4; i++)
      m_pend[i] = m_mode[i] ? (ev[i] | (m_pend[i] & ~clr[i])) : h2[i];
    if (bus.cfg_wren) begin
      if (bus.cfg_addr == 2'd0) m_en   = bus.cfg_wdata[0];
      if (bus.cfg_addr == 2'd1) m_mask = bus.cfg_wdata[3:0];
      if (bus.cfg_addr == 2'd2) m_mode = bus.cfg_wdata[3:0];
    end
    h3 = h2; h2 = h1; h1 = ext;
    m_phase = nphase;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m_en};
      2'd1:    return {28'd0, m_mask};
      2'd2:    return {28'd0, m_mode};
      default: return {28'd0, m_pend};
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (drive only)
  // --------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wren = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    cycle();
    bus.cfg_wren = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1; cycle(); bus.int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.int_done = 1'b1; cycle(); bus.int_done = 1'b0;
  endtask

  task automatic pulse_line(input logic [3:0] v);
    ext = v; cycle(); ext = 4'd0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    n_tests++;
    if ({bus.int_req, bus.int_active, bus.int_id, bus.int_vector} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b act=%b id=%0d vec=%h, required all 0",
               bus.int_req, bus.int_active, bus.int_id, bus.int_vector);
    end
    for (int a = 0; a < 4; a++) begin
      bus.cfg_addr = 2'(a); #1;
      n_tests++;
      if (bus.cfg_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 0", a, bus.cfg_rdata);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_edge_latency();
    cfg_write(2'd0, 32'd1);
    cfg_write(2'd1, 32'h1);
    cfg_write(2'd2, 32'h1);
    bus.cfg_addr = 2'd3;
    pulse_line(4'h1);          // E0
    cycle();                   // E1
    n_tests++;
    if (bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL latency_e1_req: got %b, required 0", bus.int_req);
    end
    cycle();                   // E2
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.cfg_rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL latency_e2: req=%b pend=%h, required req=0 pend=1", bus.int_req, bus.cfg_rdata);
    end
    cycle();                   // E3
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd0 || bus.int_vector !== 16'h0004) begin
      n_fail++;
      $display("FAIL latency_e3: req=%b id=%0d vec=%h, required 1/0/0004",
               bus.int_req, bus.int_id, bus.int_vector);
    end
    pulse_ack();
    n_tests++;
    if (bus.int_active !== 1'b1 || bus.int_req !== 1'b0 || bus.cfg_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL latency_ack: act=%b req=%b pend=%h, required 1/0/0",
               bus.int_active, bus.int_req, bus.cfg_rdata);
    end
    pulse_done();
    n_tests++;
    if (bus.int_active !== 1'b0) begin
      n_fail++; $display("FAIL latency_done: act=%b, required 0", bus.int_active);
    end
  endtask

  task automatic test_priority();
    cfg_write(2'd1, 32'hF);
    cfg_write(2'd2, 32'hF);
    pulse_line(4'b1010);
    for (int k = 0; k < 8 && !bus.int_req; k++) cycle();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd1 || bus.int_vector !== 16'h0008) begin
      n_fail++;
      $display("FAIL prio_first: req=%b id=%0d vec=%h, required 1/1/0008",
               bus.int_req, bus.int_id, bus.int_vector);
    end
    pulse_ack();
    pulse_done();
    n_tests++;
    if (bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle_gap: req=%b, required 0", bus.int_req);
    end
    cycle();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd3 || bus.int_vector !== 16'h0010) begin
      n_fail++;
      $display("FAIL prio_second: req=%b id=%0d vec=%h, required 1/3/0010",
               bus.int_req, bus.int_id, bus.int_vector);
    end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_masked_pending();
    int seen;
    cfg_write(2'd1, 32'h0);
    bus.cfg_addr = 2'd3;
    pulse_line(4'h4);
    seen = 0;
    repeat (5) begin
      cycle();
      if (bus.int_req !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0 || bus.cfg_rdata !== 32'h4) begin
      n_fail++;
      $display("FAIL masked_pend: req_cycles=%0d pend=%h, required 0/4", seen, bus.cfg_rdata);
    end
    cfg_write(2'd1, 32'h4);
    bus.cfg_addr = 2'd3;
    n_tests++;
    if (bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL unmask_clk1: req=%b, required 0", bus.int_req);
    end
    cycle();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd2 || bus.int_vector !== 16'h000C) begin
      n_fail++;
      $display("FAIL unmask_clk2: req=%b id=%0d vec=%h, required 1/2/000c",
               bus.int_req, bus.int_id, bus.int_vector);
    end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_level();
    cfg_write(2'd2, 32'h0);
    cfg_write(2'd1, 32'h2);
    ext = 4'h2;
    for (int k = 0; k < 8 && !bus.int_req; k++) cycle();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd1) begin
      n_fail++; $display("FAIL level_req: req=%b id=%0d, required 1/1", bus.int_req, bus.int_id);
    end
    pulse_ack();
    pulse_done();
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.int_active !== 1'b0) begin
      n_fail++; $display("FAIL level_gap: req=%b act=%b, required 0/0", bus.int_req, bus.int_active);
    end
    cycle();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd1) begin
      n_fail++; $display("FAIL level_rereq: req=%b id=%0d, required 1/1", bus.int_req, bus.int_id);
    end
    cfg_write(2'd3, 32'h2);
    bus.cfg_addr = 2'd3; #1;
    n_tests++;
    if (bus.cfg_rdata !== 32'h2) begin
      n_fail++; $display("FAIL level_w1c: pend=%h, required 2", bus.cfg_rdata);
    end
    ext = 4'h0;
    repeat (4) cycle();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 2'd1) begin
      n_fail++; $display("FAIL level_drop_in_req: req=%b id=%0d, required 1/1", bus.int_req, bus.int_id);
    end
    pulse_ack();
    pulse_done();
    repeat (3) cycle();
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.cfg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL level_quiet: req=%b pend=%h, required 0/0", bus.int_req, bus.cfg_rdata);
    end
  endtask

  task automatic test_w1c_race();
    cfg_write(2'd2, 32'hF);
    cfg_write(2'd1, 32'h0);
    pulse_line(4'h1);          // E0
    cycle();                   // E1
    bus.cfg_wren = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_wdata = 32'h1;
    cycle();                   // E2: edge reaches pending as W1C lands
    bus.cfg_wren = 1'b0; #1;
    n_tests++;
    if (bus.cfg_rdata !== 32'h1) begin
      n_fail++; $display("FAIL w1c_race: pend=%h, required 1", bus.cfg_rdata);
    end
    cfg_write(2'd3, 32'h1);
    bus.cfg_addr = 2'd3; #1;
    n_tests++;
    if (bus.cfg_rdata !== 32'h0) begin
      n_fail++; $display("FAIL w1c_clear: pend=%h, required 0", bus.cfg_rdata);
    end
    pulse_ack();
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.int_active !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack: req=%b act=%b, required 0/0", bus.int_req, bus.int_active);
    end
    cfg_write(2'd1, 32'h1);
    pulse_line(4'h1);
    for (int k = 0; k < 8 && !bus.int_req; k++) cycle();
    bus.int_ack = 1'b1; bus.int_done = 1'b1;
    cycle();
    bus.int_ack = 1'b0; bus.int_done = 1'b0;
    n_tests++;
    if (bus.int_active !== 1'b1 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL ack_done_req: act=%b req=%b, required 1/0", bus.int_active, bus.int_req);
    end
    pulse_done();
    n_tests++;
    if (bus.int_active !== 1'b0 || bus.int_req !== 1'b0) begin
      n_fail++; $display("FAIL ack_done_exit: act=%b req=%b, required 0/0", bus.int_active, bus.int_req);
    end
  endtask

  task automatic test_async_reset();
    pulse_line(4'h1);
    for (int k = 0; k < 8 && !bus.int_req; k++) cycle();
    pulse_ack();
    n_tests++;
    if (bus.int_active !== 1'b1) begin
      n_fail++; $display("FAIL areset_setup: act=%b, required 1", bus.int_active);
    end
    bus.cfg_addr = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.int_active !== 1'b0 || bus.int_req !== 1'b0 || bus.cfg_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: act=%b req=%b ctrl=%h, required 0/0/0",
               bus.int_active, bus.int_req, bus.cfg_rdata);
    end
    bus.cfg_addr = 2'd1; #1;
    n_tests++;
    if (bus.cfg_rdata !== 32'd0) begin
      n_fail++; $display("FAIL areset_mask: mask=%h, required 0", bus.cfg_rdata);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    cfg_write(2'd0, 32'd1);
    cfg_write(2'd1, 32'hF);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) ext = ext ^ 4'($urandom);
      bus.int_ack   = ($urandom_range(0, 3) == 0);
      bus.int_done  = ($urandom_range(0, 4) == 0);
      bus.cfg_wren  = ($urandom_range(0, 9) == 0);
      bus.cfg_addr  = 2'($urandom);
      bus.cfg_wdata = $urandom;
      if (bus.cfg_addr == 2'd0) bus.cfg_wdata[0] = ($urandom_range(0, 7) != 0);
      cycle();
      n_tests++;
      if (bus.int_req !== (m_phase == 1) || bus.int_active !== (m_phase == 2) ||
          bus.int_id !== 2'(m_id) || bus.int_vector !== m_vec ||
          bus.cfg_rdata !== model_rdata(bus.cfg_addr)) begin
        n_fail++;
        $display("FAIL random cyc=%0d: req=%b act=%b id=%0d vec=%h rd=%h, required req=%b act=%b id=%0d vec=%h rd=%h",
                 cyc, bus.int_req, bus.int_active, bus.int_id, bus.int_vector, bus.cfg_rdata,
                 (m_phase == 1), (m_phase == 2), m_id, m_vec, model_rdata(bus.cfg_addr));
      end
    end
    bus.cfg_wren = 1'b0; bus.int_ack = 1'b0; bus.int_done = 1'b0; ext = 4'd0;
  endtask

  initial begin
    bus.cfg_wren  = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 32'd0;
    bus.int_ack   = 1'b0;
    bus.int_done  = 1'b0;
    test_reset();
    test_edge_latency();
    test_priority();
    test_masked_pending();
    test_level();
    test_w1c_race();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
